// File: rtl/activation_plan_if.sv
// -----------------------------------------------------------------------------
// activation_plan_if
// Handshake bundle for the activation unit.
//   mode      : function select, sampled when a sample is accepted
//   in_valid  : upstream has a sample on in_data
//   in_ready  : unit can take a sample (IDLE only)
//   in_data   : signed fixed-point input sample
//   out_valid : result present on out_data
//   out_ready : downstream takes the result
//   out_data  : signed fixed-point result, same Q format as in_data
//   busy      : unit is working on a sample
// master = sample source / result sink, slave = activation unit.
// -----------------------------------------------------------------------------
interface activation_plan_if #(
    parameter int DATA_W = 16
);
    logic [1:0]               mode;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/activation_plan.sv
// -----------------------------------------------------------------------------
// activation_plan
// Fixed-point sigmoid / tanh / SiLU using PLAN piecewise-linear segments with
// shift-only slopes. One sample in flight; SiLU finishes with a radix-2
// shift-add multiply of x by sigmoid(x).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : activation_plan_if.slave (mode, in_*, out_*, busy)
// Parameters:
//   DATA_W : sample width (signed), must be >= FRAC_W+4
//   FRAC_W : fractional bits, 1.0 = 2**FRAC_W (FRAC_W >= 5)
// -----------------------------------------------------------------------------
module activation_plan #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    activation_plan_if.slave  bus
);
    localparam int W1    = DATA_W + 1;
    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    // PLAN breakpoints and offsets, expressed relative to 1.0 so they scale with FRAC_W
    localparam logic signed [W1-1:0] ONE   = W1'(1)  <<< FRAC_W;
    localparam logic signed [W1-1:0] T_SAT = W1'(5)  <<< FRAC_W;        // 5.0
    localparam logic signed [W1-1:0] T_MID = W1'(19) <<< (FRAC_W - 3);  // 2.375
    localparam logic signed [W1-1:0] C_HI  = W1'(27) <<< (FRAC_W - 5);  // 0.84375
    localparam logic signed [W1-1:0] C_MID = W1'(5)  <<< (FRAC_W - 3);  // 0.625
    localparam logic signed [W1-1:0] C_LO  = W1'(1)  <<< (FRAC_W - 1);  // 0.5

    localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ABS, S_SEG, S_MIRROR, S_MUL, S_OUT
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] x_r;
    logic [1:0]               mode_r;
    logic                     neg_r;
    logic [DATA_W-1:0]        a_r;
    logic signed [W1-1:0]     y_r;
    logic signed [PW-1:0]     acc_r;
    logic signed [PW-1:0]     mcand_r;
    logic [DATA_W-1:0]        mplier_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [DATA_W-1:0] out_r;

    logic signed [DATA_W-1:0] xp;
    logic [DATA_W-1:0]        a_nxt;
    logic signed [W1-1:0]     a_ext;
    logic signed [W1-1:0]     y_nxt;
    logic signed [W1-1:0]     ym;
    logic signed [PW-1:0]     acc_nxt;

    // Clamp a one-bit-wider value back into DATA_W
    function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [W1-1:0] v);
        if (v[W1-1] != v[W1-2])
            return v[W1-1] ? DMIN : DMAX;
        else
            return v[DATA_W-1:0];
    endfunction

    // Magnitude with the most negative code folded onto the largest positive one
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
        if (v == DMIN)
            return DMAX;
        else if (v[DATA_W-1])
            return -v;
        else
            return v;
    endfunction

    always_comb begin
        xp      = (mode_r == 2'b01) ? sat_w($signed({x_r, 1'b0})) : x_r;
        a_nxt   = abs_sat(xp);
        a_ext   = $signed({1'b0, a_r});
        if (a_ext >= T_SAT)
            y_nxt = ONE;
        else if (a_ext >= T_MID)
            y_nxt = (a_ext >> 5) + C_HI;
        else if (a_ext >= ONE)
            y_nxt = (a_ext >> 3) + C_MID;
        else
            y_nxt = (a_ext >> 2) + C_LO;
        // x' has the sign of x, so the latched sign selects the mirror
        ym      = neg_r ? (ONE - y_r) : y_r;
        acc_nxt = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.in_valid) state_nxt = S_ABS;
            S_ABS:    state_nxt = S_SEG;
            S_SEG:    state_nxt = S_MIRROR;
            S_MIRROR: state_nxt = (mode_r == 2'b10) ? S_MUL : S_OUT;
            S_MUL:    if (cnt_r == LAST) state_nxt = S_OUT;
            S_OUT:    if (bus.out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r      <= '0;
            mode_r   <= '0;
            neg_r    <= 1'b0;
            a_r      <= '0;
            y_r      <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            out_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_r    <= bus.in_data;
                        mode_r <= bus.mode;
                        neg_r  <= bus.in_data[DATA_W-1];
                    end
                end
                S_ABS: a_r <= a_nxt;
                S_SEG: y_r <= y_nxt;
                S_MIRROR: begin
                    case (mode_r)
                        2'b01: out_r <= DATA_W'((ym <<< 1) - ONE);
                        2'b10: begin
                            mcand_r  <= {{DATA_W{x_r[DATA_W-1]}}, x_r};
                            mplier_r <= ym[DATA_W-1:0];
                            acc_r    <= '0;
                            cnt_r    <= '0;
                        end
                        default: out_r <= ym[DATA_W-1:0];
                    endcase
                end
                S_MUL: begin
                    acc_r    <= acc_nxt;
                    mcand_r  <= mcand_r <<< 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    // Dropping the low FRAC_W bits is an arithmetic shift rounding toward -inf
                    if (cnt_r == LAST)
                        out_r <= acc_nxt[FRAC_W +: DATA_W];
                end
                default: ;
            endcase
        end
    end

    // in_ready is gated by reset so it reads 0 while reset is held
    assign bus.in_ready  = reset && (state == S_IDLE);
    assign bus.out_valid = (state == S_OUT);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_data  = out_r;
endmodule
